tile_map_arbiter: RTL and testbench

Owns the 16x16 tile-type map that the VGA texture pipeline reads each pixel. Shares that single-port map between three requesters: the VGA pixel path, the game logic's tile writes, and the game logic's collision reads. Also provides a self-timed whole-map clear. Sits between the snake game logic and the pixel-to-texture lookup, and supplies the 5-bit tile type that selects the texture.

---
 rtl/tile_map_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_tile_map_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_map_arbiter.sv
// tile_map_arbiter: owns the 16x16 tile-type map read by the VGA texture pipeline and
// shares its single port between VGA reads, buffered game writes, game reads and a
// self-timed whole-map clear.
module tile_map_arbiter #(
    parameter int unsigned MAP_BITS   = 4,
    parameter int unsigned TILE_BITS  = 5,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CLEAR_TILE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // VGA pixel path
    input  logic                 vga_req,
    input  logic [MAP_BITS-1:0]  vga_map_x,
    input  logic [MAP_BITS-1:0]  vga_map_y,
    output logic [TILE_BITS-1:0] vga_tile,
    output logic                 vga_valid,
    // game logic tile writes
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [MAP_BITS-1:0]  wr_x,
    input  logic [MAP_BITS-1:0]  wr_y,
    input  logic [TILE_BITS-1:0] wr_tile,
    // game logic collision reads
    input  logic                 rd_valid,
    output logic                 rd_ready,
    input  logic [MAP_BITS-1:0]  rd_x,
    input  logic [MAP_BITS-1:0]  rd_y,
    output logic [TILE_BITS-1:0] rd_data,
    output logic                 rd_data_valid,
    // whole-map clear
    input  logic                 clr_start,
    output logic                 busy
);

    localparam int unsigned ADDR_W = 2 * MAP_BITS;
    localparam int unsigned CELLS  = 1 << ADDR_W;
    // FIFO_DEPTH must be a power of two >= 2 so the pointers wrap naturally
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]    addr;
        logic [TILE_BITS-1:0] tile;
    } wr_entry_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    clr_cnt_q, clr_cnt_d;

    wr_entry_t            fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     fifo_cnt_q, fifo_cnt_d;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    wr_entry_t            fifo_head;
    wr_entry_t            fifo_in;

    logic [TILE_BITS-1:0] mem_q [CELLS];
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_waddr;
    logic [TILE_BITS-1:0] mem_wdata;

    logic [ADDR_W-1:0]    vga_addr;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 rd_fire;

    logic [TILE_BITS-1:0] vga_tile_q, vga_tile_d;
    logic                 vga_valid_q, vga_valid_d;
    logic [TILE_BITS-1:0] rd_data_q, rd_data_d;
    logic                 rd_data_valid_q, rd_data_valid_d;

    // Handshake decode; wr_ready looks only at the stored count, never at this cycle's pop
    assign vga_addr   = {vga_map_y, vga_map_x};
    assign rd_addr    = {rd_y, rd_x};
    assign fifo_empty = (fifo_cnt_q == '0);
    assign wr_ready   = (fifo_cnt_q != CNT_W'(FIFO_DEPTH));
    assign rd_ready   = !vga_req && (state_q == ST_IDLE) && fifo_empty;
    assign fifo_push  = wr_valid && wr_ready;
    assign rd_fire    = rd_valid && rd_ready;
    assign fifo_head  = fifo_q[rd_ptr_q];
    assign fifo_in    = '{addr: {wr_y, wr_x}, tile: wr_tile};

    assign busy          = (state_q == ST_CLEAR);
    assign vga_tile      = vga_tile_q;
    assign vga_valid     = vga_valid_q;
    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_data_valid_q;

    // Port grant (VGA > clear > FIFO head > logic read) and clear FSM next state
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        fifo_pop  = 1'b0;

        if (!vga_req) begin
            if (state_q == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = TILE_BITS'(CLEAR_TILE);
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == ADDR_W'(CELLS - 1)) begin
                    state_d = ST_IDLE;
                end
            end else if (!fifo_empty) begin
                mem_we    = 1'b1;
                mem_waddr = fifo_head.addr;
                mem_wdata = fifo_head.tile;
                fifo_pop  = 1'b1;
            end
        end

        // clr_start is ignored while a clear is already running
        if ((state_q == ST_IDLE) && clr_start) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
        end
    end

    // Write FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d   = fifo_push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d   = fifo_pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    end

    // Read-data capture; data registers hold between requests
    always_comb begin
        vga_valid_d     = vga_req;
        vga_tile_d      = vga_req ? mem_q[vga_addr] : vga_tile_q;
        rd_data_valid_d = rd_fire;
        rd_data_d       = rd_fire ? mem_q[rd_addr] : rd_data_q;
    end

    // Control state, FIFO pointers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            clr_cnt_q       <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            fifo_cnt_q      <= '0;
            vga_tile_q      <= '0;
            vga_valid_q     <= 1'b0;
            rd_data_q       <= '0;
            rd_data_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            clr_cnt_q       <= clr_cnt_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            fifo_cnt_q      <= fifo_cnt_d;
            vga_tile_q      <= vga_tile_d;
            vga_valid_q     <= vga_valid_d;
            rd_data_q       <= rd_data_d;
            rd_data_valid_q <= rd_data_valid_d;
        end
    end

    // FIFO payload storage; occupancy is tracked by the reset pointers
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_q[wr_ptr_q] <= fifo_in;
        end
    end

    // Tile map storage; contents survive reset and are initialised by a clear
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_tile_map_arbiter.sv
// tb_tile_map_arbiter: directed and random stimulus for tile_map_arbiter against a
// transaction-level map/queue reference.
module tb_tile_map_arbiter;

    localparam int unsigned FD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vga_req;
    logic [3:0] vga_map_x, vga_map_y;
    logic [4:0] vga_tile;
    logic       vga_valid;
    logic       wr_valid, wr_ready;
    logic [3:0] wr_x, wr_y;
    logic [4:0] wr_tile;
    logic       rd_valid, rd_ready;
    logic [3:0] rd_x, rd_y;
    logic [4:0] rd_data;
    logic       rd_data_valid;
    logic       clr_start, busy;

    always #5 clk = ~clk;

    tile_map_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vga_req      (vga_req),
        .vga_map_x    (vga_map_x),
        .vga_map_y    (vga_map_y),
        .vga_tile     (vga_tile),
        .vga_valid    (vga_valid),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .wr_tile      (wr_tile),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_x         (rd_x),
        .rd_y         (rd_y),
        .rd_data      (rd_data),
        .rd_data_valid(rd_data_valid),
        .clr_start    (clr_start),
        .busy         (busy)
    );

    int total = 0;
    int bad   = 0;

    // reference: map contents, pending write queue, clear progress, expected outputs
    logic [4:0]  m_map [256];
    logic [12:0] m_q [$];
    bit          m_busy;
    int          m_cnt;
    logic [4:0]  e_vga_tile, e_rd_data;
    bit          e_vga_valid, e_rd_dv;

    int bx [5] = '{0, 1, 2, 7, 7};
    int by [5] = '{4, 4, 4, 7, 7};
    int bt [5] = '{10, 11, 12, 20, 21};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy      = 1'b0;
        m_cnt       = 0;
        e_vga_tile  = '0;
        e_rd_data   = '0;
        e_vga_valid = 1'b0;
        e_rd_dv     = 1'b0;
    endtask

    task automatic set_idle();
        vga_req   = 1'b0;
        vga_map_x = '0;
        vga_map_y = '0;
        wr_valid  = 1'b0;
        wr_x      = '0;
        wr_y      = '0;
        wr_tile   = '0;
        rd_valid  = 1'b0;
        rd_x      = '0;
        rd_y      = '0;
        clr_start = 1'b0;
    endtask

    // one clock: predict this edge from the rules, then compare outputs after it
    task automatic cycle();
        bit         pre_busy, exp_wrr, exp_rdr, push;
        logic [12:0] ent;
        #1;
        pre_busy = m_busy;
        exp_wrr  = (m_q.size() != FD);
        exp_rdr  = !vga_req && !m_busy && (m_q.size() == 0);
        check("wr_ready", wr_ready, exp_wrr);
        check("rd_ready", rd_ready, exp_rdr);
        push        = wr_valid && exp_wrr;
        e_vga_valid = vga_req;
        e_rd_dv     = 1'b0;
        if (vga_req) begin
            e_vga_tile = m_map[{vga_map_y, vga_map_x}];
        end else if (m_busy) begin
            m_map[m_cnt] = 5'd0;
            m_cnt++;
            if (m_cnt == 256) m_busy = 1'b0;
        end else if (m_q.size() != 0) begin
            ent = m_q.pop_front();
            m_map[ent[12:5]] = ent[4:0];
        end else if (rd_valid) begin
            e_rd_dv   = 1'b1;
            e_rd_data = m_map[{rd_y, rd_x}];
        end
        if (push) m_q.push_back({wr_y, wr_x, wr_tile});
        if (clr_start && !pre_busy) begin
            m_busy = 1'b1;
            m_cnt  = 0;
        end
        @(posedge clk);
        #1;
        check("vga_valid", vga_valid, e_vga_valid);
        check("vga_tile", vga_tile, e_vga_tile);
        check("rd_data_valid", rd_data_valid, e_rd_dv);
        check("rd_data", rd_data, e_rd_data);
        check("busy", busy, m_busy);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         acc;
        bit         got;
        bit         fire;
        logic [4:0] old;

        rst_n = 1'b0;
        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_vga_tile", vga_tile, 0);
        check("rst_vga_valid", vga_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_dv", rd_data_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_rd_ready", rd_ready, 1);
        vga_req = 1'b1;
        #1;
        check("rst_rd_ready_vga", rd_ready, 0);
        vga_req = 1'b0;
        rst_n   = 1'b1;

        // basic write then VGA read
        wr_valid = 1'b1; wr_x = 4'd3; wr_y = 4'd5; wr_tile = 5'd7;
        cycle();
        wr_valid = 1'b0;
        cycle();
        cycle();
        vga_req = 1'b1; vga_map_x = 4'd3; vga_map_y = 4'd5;
        cycle();
        vga_req = 1'b0;
        check("basic_tile", vga_tile, 7);
        check("basic_valid", vga_valid, 1);

        // unobstructed clear
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        n = busy ? 1 : 0;
        for (int i = 0; i < 600 && busy; i++) begin
            cycle();
            if (busy) n++;
        end
        check("clr_len", n, 256);
        vga_req = 1'b1; vga_map_x = 4'd0; vga_map_y = 4'd0;
        cycle();
        check("clr_cell_0_0", vga_tile, 0);
        vga_map_x = 4'd15; vga_map_y = 4'd15;
        cycle();
        check("clr_cell_15_15", vga_tile, 0);

        // FIFO backpressure under continuous VGA
        vga_map_x = 4'd0; vga_map_y = 4'd0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_x = 4'(bx[i]); wr_y = 4'(by[i]); wr_tile = 5'(bt[i]);
            #1;
            if (wr_ready === 1'b1) acc++;
            if (i == 4) check("bp_full", wr_ready, 0);
            cycle();
        end
        check("bp_accepts", acc, 4);
        vga_req = 1'b0;
        cycle();
        check("bp_ready_after_pop", wr_ready, 1);
        cycle();
        wr_valid = 1'b0;
        for (int i = 0; i < 20 && m_q.size() != 0; i++) cycle();
        check("bp_drained", rd_ready, 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) continue;
            vga_req = 1'b1; vga_map_x = 4'(bx[i]); vga_map_y = 4'(by[i]);
            cycle();
            check("bp_order", vga_tile, bt[i]);
        end
        vga_req = 1'b0;

        // clear preempted by alternating VGA, with a write queued during it
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        n = busy ? 1 : 0;
        for (int c = 0; c < 1200 && busy; c++) begin
            vga_req   = (c % 2 == 0);
            vga_map_x = 4'($urandom);
            vga_map_y = 4'($urandom);
            wr_valid  = (c == 0);
            wr_x = 4'd2; wr_y = 4'd2; wr_tile = 5'd9;
            #1;
            check("ovl_rd_ready", rd_ready, 0);
            cycle();
            if (busy) n++;
        end
        wr_valid = 1'b0;
        vga_req  = 1'b0;
        check("ovl_len", n, 512);
        cycle();
        cycle();
        vga_req = 1'b1; vga_map_x = 4'd2; vga_map_y = 4'd2;
        cycle();
        check("ovl_cell_2_2", vga_tile, 9);
        vga_req = 1'b0;

        // read waits behind an earlier accepted write
        vga_req = 1'b1;
        wr_valid = 1'b1; wr_x = 4'd1; wr_y = 4'd1; wr_tile = 5'd12;
        rd_valid = 1'b1; rd_x = 4'd1; rd_y = 4'd1;
        cycle();
        wr_valid = 1'b0;
        vga_req  = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            fire = (rd_ready === 1'b1);
            if (m_q.size() != 0) check("raw_wait", rd_ready, 0);
            cycle();
            if (fire) begin
                got      = 1'b1;
                rd_valid = 1'b0;
                check("raw_dv", rd_data_valid, 1);
                check("raw_data", rd_data, 12);
            end
        end
        check("raw_done", got, 1);
        rd_valid = 1'b0;

        // random traffic
        for (int c = 0; c < 2000; c++) begin
            vga_req   = ($urandom_range(0, 99) < 45);
            vga_map_x = 4'($urandom);
            vga_map_y = 4'($urandom);
            wr_valid  = ($urandom_range(0, 99) < 40);
            wr_x      = 4'($urandom);
            wr_y      = 4'($urandom);
            wr_tile   = 5'($urandom);
            rd_valid  = ($urandom_range(0, 99) < 30);
            rd_x      = 4'($urandom);
            rd_y      = 4'($urandom);
            clr_start = ($urandom_range(0, 999) < 3);
            cycle();
        end
        set_idle();
        for (int i = 0; i < 600 && (m_busy || m_q.size() != 0); i++) cycle();

        // reset in the middle of a clear with a write pending
        clr_start = 1'b1;
        cycle();
        clr_start = 1'b0;
        wr_valid = 1'b1; wr_x = 4'd5; wr_y = 4'd9; wr_tile = 5'd3;
        cycle();
        wr_valid = 1'b0;
        for (int i = 0; i < 400 && m_cnt < 100; i++) cycle();
        vga_req = 1'b1;
        cycle();
        check("pre_rst_busy", busy, 1);
        check("pre_rst_vga_valid", vga_valid, 1);
        old = m_map[9 * 16 + 5];
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_vga_valid", vga_valid, 0);
        check("mid_rst_rd_dv", rd_data_valid, 0);
        check("mid_rst_vga_tile", vga_tile, 0);
        check("mid_rst_wr_ready", wr_ready, 1);
        vga_req = 1'b0;
        #1;
        check("mid_rst_fifo_empty", rd_ready, 1);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        cycle();
        vga_req = 1'b1; vga_map_x = 4'd5; vga_map_y = 4'd9;
        cycle();
        check("rst_write_dropped", vga_tile, old);
        vga_map_x = 4'd3; vga_map_y = 4'd6;
        cycle();
        check("rst_cleared_cell", vga_tile, 0);
        vga_map_x = 4'd4; vga_map_y = 4'd6;
        cycle();
        vga_req = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
